// File: rtl/me_branch_redirect.sv
// Memory-stage branch resolver: evaluates branch/jump conditions in ME, issues a one-cycle
// fetch redirect and holds a flush window over F/D/E. Optional statistics: BRANCH_STATS_EN.
module me_branch_redirect #(
    parameter int PC_W        = 32,
    parameter int DATA_W      = 32,
    parameter int FLUSH_DEPTH = 3
`ifdef BRANCH_STATS_EN
   ,parameter int STAT_W      = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic              is_branch_i,
    input  logic              is_jump_i,
    input  logic [2:0]        br_type_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    input  logic [PC_W-1:0]   target_i,
    output logic              pc_src_o,
    output logic [PC_W-1:0]   pc_branch_o,
    output logic              flush_o,
    output logic              busy_o
`ifdef BRANCH_STATS_EN
   ,output logic [STAT_W-1:0] stat_taken_o,
    output logic [STAT_W-1:0] stat_ntaken_o
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    // The FLUSH state covers the FLUSH_DEPTH-1 cycles that follow the redirect cycle.
    localparam int CNT_W = (FLUSH_DEPTH > 2) ? $clog2(FLUSH_DEPTH - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((FLUSH_DEPTH > 1) ? (FLUSH_DEPTH - 2) : 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pc_src_q, pc_src_d;
    logic [PC_W-1:0]   pc_branch_q, pc_branch_d;
    logic              flush_q, flush_d;
    logic              busy_q, busy_d;
    logic              cond_s;
    logic              take_s;
    logic              ntake_s;

    function automatic logic branch_cond(input logic [2:0]        br_type,
                                         input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b);
        logic c;
        c = 1'b0;
        case (br_type)
            3'b000:  c = (a == b);
            3'b001:  c = (a != b);
            3'b100:  c = ($signed(a) <  $signed(b));
            3'b101:  c = ($signed(a) >= $signed(b));
            3'b110:  c = (a <  b);
            3'b111:  c = (a >= b);
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    // Branch resolution; anything arriving while flush_o is high is wrong-path.
    always_comb begin
        cond_s  = branch_cond(br_type_i, op_a_i, op_b_i);
        take_s  = valid_i & ~flush_q & (is_jump_i | (is_branch_i & cond_s));
        ntake_s = valid_i & ~flush_q & ~is_jump_i & is_branch_i & ~cond_s;
    end

    // Next-state logic and the next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_branch_d = pc_branch_q;
        case (state_q)
            IDLE: begin
                if (take_s) begin
                    state_d     = REDIRECT;
                    pc_branch_d = target_i;
                end else begin
                    state_d = IDLE;
                end
            end
            REDIRECT: begin
                cnt_d = {CNT_W{1'b0}};
                if (FLUSH_DEPTH > 1) begin
                    state_d = FLUSH;
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        pc_src_d = (state_d == REDIRECT);
        flush_d  = (state_d != IDLE);
        busy_d   = (state_d != IDLE);
    end

    // State and output registers; reset discards any pending redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            pc_src_q    <= 1'b0;
            pc_branch_q <= {PC_W{1'b0}};
            flush_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_src_q    <= pc_src_d;
            pc_branch_q <= pc_branch_d;
            flush_q     <= flush_d;
            busy_q      <= busy_d;
        end
    end

    assign pc_src_o    = pc_src_q;
    assign pc_branch_o = pc_branch_q;
    assign flush_o     = flush_q;
    assign busy_o      = busy_q;

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] stat_taken_q;
    logic [STAT_W-1:0] stat_ntaken_q;

    // Statistics counters wrap naturally at 2^STAT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_taken_q  <= {STAT_W{1'b0}};
            stat_ntaken_q <= {STAT_W{1'b0}};
        end else begin
            if (take_s) begin
                stat_taken_q <= stat_taken_q + STAT_W'(1);
            end else begin
                stat_taken_q <= stat_taken_q;
            end
            if (ntake_s) begin
                stat_ntaken_q <= stat_ntaken_q + STAT_W'(1);
            end else begin
                stat_ntaken_q <= stat_ntaken_q;
            end
        end
    end

    assign stat_taken_o  = stat_taken_q;
    assign stat_ntaken_o = stat_ntaken_q;
`endif

endmodule

// File: tb/tb_me_branch_redirect.sv
// Bench for me_branch_redirect: two instances (flush depth 3 and 1) share stimulus and are
// checked against a cycle-level reference model with a redirect-target scoreboard.
module tb_me_branch_redirect;

    localparam int NI = 2;

    logic        clk;
    logic        reset;
    logic        valid_i;
    logic        is_branch_i;
    logic        is_jump_i;
    logic [2:0]  br_type_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic [31:0] target_i;

    logic        pc_src_w   [NI];
    logic [31:0] pc_branch_w[NI];
    logic        flush_w    [NI];
    logic        busy_w     [NI];
`ifdef BRANCH_STATS_EN
    logic [3:0]  stat_t_w   [NI];
    logic [3:0]  stat_n_w   [NI];
`endif

    int n_vec;
    int n_fail;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        me_branch_redirect #(
            .PC_W       (32),
            .DATA_W     (32),
            .FLUSH_DEPTH((g == 0) ? 3 : 1)
`ifdef BRANCH_STATS_EN
           ,.STAT_W     (4)
`endif
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .valid_i    (valid_i),
            .is_branch_i(is_branch_i),
            .is_jump_i  (is_jump_i),
            .br_type_i  (br_type_i),
            .op_a_i     (op_a_i),
            .op_b_i     (op_b_i),
            .target_i   (target_i),
            .pc_src_o   (pc_src_w[g]),
            .pc_branch_o(pc_branch_w[g]),
            .flush_o    (flush_w[g]),
            .busy_o     (busy_w[g])
`ifdef BRANCH_STATS_EN
           ,.stat_taken_o (stat_t_w[g]),
            .stat_ntaken_o(stat_n_w[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: remaining flush cycles, expected outputs, pending redirect targets.
    int          depth   [NI];
    int          rem     [NI];
    logic        exp_src [NI];
    logic [31:0] exp_last[NI];
    logic [3:0]  exp_st  [NI];
    logic [3:0]  exp_sn  [NI];
    logic [31:0] tq      [NI][$];

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (depth %0d) at %0t: got %h expected %h", name, depth[inst], $time, act, exp);
        end
    endtask

    function automatic logic ref_cond(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] sa;
        logic [31:0] sb;
        sa = a ^ 32'h8000_0000;
        sb = b ^ 32'h8000_0000;
        if (t == 3'd0)      return a == b;
        else if (t == 3'd1) return a != b;
        else if (t == 3'd4) return sa < sb;
        else if (t == 3'd5) return !(sa < sb);
        else if (t == 3'd6) return a < b;
        else if (t == 3'd7) return !(a < b);
        else                return 1'b0;
    endfunction

    // Monitor + model: check this cycle's outputs, then advance the model over the next edge.
    initial begin
        logic [31:0] t;
        logic        cur_f;
        logic        c;
        logic        take;
        for (int i = 0; i < NI; i++) begin
            depth[i] = (i == 0) ? 3 : 1;
            rem[i] = 0; exp_src[i] = 1'b0; exp_last[i] = 32'd0;
            exp_st[i] = 4'd0; exp_sn[i] = 4'd0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                chk("pc_src", i, {31'd0, pc_src_w[i]}, {31'd0, exp_src[i]});
                chk("flush", i, {31'd0, flush_w[i]}, {31'd0, rem[i] > 0});
                chk("busy", i, {31'd0, busy_w[i]}, {31'd0, rem[i] > 0});
                chk("pc_branch_hold", i, pc_branch_w[i], exp_last[i]);
                if (pc_src_w[i] === 1'b1) begin
                    if (tq[i].size() == 0) begin
                        chk("unexpected_redirect", i, 32'd1, 32'd0);
                    end else begin
                        t = tq[i].pop_front();
                        chk("redirect_target", i, pc_branch_w[i], t);
                    end
                end
`ifdef BRANCH_STATS_EN
                chk("stat_taken", i, {28'd0, stat_t_w[i]}, {28'd0, exp_st[i]});
                chk("stat_ntaken", i, {28'd0, stat_n_w[i]}, {28'd0, exp_sn[i]});
`endif
                cur_f = (rem[i] > 0);
                if (reset) begin
                    rem[i] = 0; exp_src[i] = 1'b0; exp_last[i] = 32'd0;
                    exp_st[i] = 4'd0; exp_sn[i] = 4'd0;
                    tq[i].delete();
                end else begin
                    c    = ref_cond(br_type_i, op_a_i, op_b_i);
                    take = valid_i && !cur_f && (is_jump_i || (is_branch_i && c));
                    if (valid_i && !cur_f && !is_jump_i && is_branch_i && !c) exp_sn[i] = exp_sn[i] + 4'd1;
                    if (take) begin
                        rem[i] = depth[i];
                        exp_src[i] = 1'b1;
                        exp_last[i] = target_i;
                        tq[i].push_back(target_i);
                        exp_st[i] = exp_st[i] + 4'd1;
                    end else begin
                        rem[i] = (rem[i] > 0) ? rem[i] - 1 : 0;
                        exp_src[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic step(input logic v, input logic br, input logic j, input logic [2:0] ty,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] tg);
        valid_i = v; is_branch_i = br; is_jump_i = j; br_type_i = ty;
        op_a_i = a; op_b_i = b; target_i = tg;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
    endtask

    // Stimulus: directed scenarios, then randomized traffic with occasional resets.
    initial begin
        logic [31:0] ext[5];
        logic [31:0] a;
        logic [31:0] b;
        int          m;
        ext[0] = 32'h0000_0000; ext[1] = 32'h0000_0001; ext[2] = 32'h7FFF_FFFF;
        ext[3] = 32'h8000_0000; ext[4] = 32'hFFFF_FFFF;
        n_vec = 0; n_fail = 0;
        reset = 1'b1;
        valid_i = 1'b0; is_branch_i = 1'b0; is_jump_i = 1'b0; br_type_i = 3'd0;
        op_a_i = 32'd0; op_b_i = 32'd0; target_i = 32'd0;
        @(posedge clk); #1;
        idle(3);
        reset = 1'b0;
        idle(2);

        step(1'b1, 1'b1, 1'b0, 3'b000, 32'd5, 32'd5, 32'h10);
        idle(5);

        step(1'b1, 1'b1, 1'b0, 3'b001, 32'd5, 32'd5, 32'h11);
        idle(1);
        step(1'b1, 1'b1, 1'b0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h12);
        idle(2);
        step(1'b1, 1'b1, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h13);
        idle(5);

        step(1'b1, 1'b0, 1'b1, 3'b000, 32'd0, 32'd0, 32'h20);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 3'b000, 32'd7, 32'd7, 32'h40);
        step(1'b1, 1'b1, 1'b0, 3'b000, 32'd7, 32'd7, 32'h40);
        idle(5);

        step(1'b1, 1'b1, 1'b0, 3'b000, 32'd1, 32'd1, 32'h55);
        idle(1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        step(1'b1, 1'b1, 1'b0, 3'b101, 32'd9, 32'd3, 32'h66);
        idle(5);

        step(1'b1, 1'b1, 1'b0, 3'b000, 32'd2, 32'd2, 32'h70);
        step(1'b1, 1'b1, 1'b0, 3'b000, 32'd2, 32'd2, 32'h71);
        idle(5);

        for (int k = 0; k < 17; k++) begin
            step(1'b1, 1'b0, 1'b1, 3'b000, 32'd0, 32'd0, 32'h100 + k);
            idle(3);
        end
        step(1'b1, 1'b1, 1'b0, 3'b010, 32'd4, 32'd4, 32'h200);
        step(1'b1, 1'b1, 1'b0, 3'b011, 32'd4, 32'd4, 32'h201);
        idle(4);

        for (int k = 0; k < 4000; k++) begin
            m = $urandom_range(0, 3);
            a = $urandom; b = $urandom;
            if (m == 0) b = a;
            else if (m == 1) begin a = $urandom_range(0, 7); b = $urandom_range(0, 7); end
            else if (m == 2) begin a = ext[$urandom_range(0, 4)]; b = ext[$urandom_range(0, 4)]; end
            reset = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                 3'($urandom_range(0, 7)), a, b, $urandom);
        end
        reset = 1'b0;
        idle(6);
        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
